// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle
//   ALU. It accepts one request at a time, iterates one bit per cycle on the
//   operand magnitudes, fixes the sign, and returns the result and a tag.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_valid      request valid          o_ready   unit idle, can accept
//   i_md_op      funct3 (MUL..REMU)     i_tag     destination tag, passthrough
//   i_operand_a  rs1 (multiplicand / dividend)
//   i_operand_b  rs2 (multiplier / divisor)
//   i_flush      synchronous abort, highest priority
//   o_valid      result valid           i_ready   consumer takes the result
//   o_result     XLEN-bit result        o_tag     tag of the returned result
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_md_op,
  input  logic [XLEN-1:0]  i_operand_a,
  input  logic [XLEN-1:0]  i_operand_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_result,
  output logic [TAG_W-1:0] o_tag
);

  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] X_ZERO = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] X_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negate of an XLEN-bit value when en is set.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    neg_x = en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement negate of a 2*XLEN-bit product when en is set.
  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
    neg_2x = en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;   // |a| for multiply, |b| for divide
  logic [2*XLEN-1:0]   acc_q, acc_d;       // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept_s;
  logic                sign_a_s, sign_b_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic                b_zero_s, div_ovf_s, special_s;
  logic [XLEN-1:0]     special_res_s;
  logic [XLEN:0]       mul_sum_s, div_rem_s, div_diff_s;
  logic [2*XLEN-1:0]   mul_next_s, div_next_s, prod_fix_s;
  logic [XLEN-1:0]     quo_fix_s, rem_fix_s, fix_res_s;

  assign accept_s = i_valid && (state_q == S_IDLE) && !i_flush;

  // Request decode: operand signs, magnitudes and the no-iteration special cases.
  always_comb begin
    sign_a_s      = 1'b0;
    sign_b_s      = 1'b0;
    special_res_s = X_ZERO;
    case (i_md_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        sign_a_s = i_operand_a[XLEN-1];
        sign_b_s = i_operand_b[XLEN-1];
      end
      OP_MULHSU: begin
        sign_a_s = i_operand_a[XLEN-1];
        sign_b_s = 1'b0;
      end
      default: begin
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
      end
    endcase
    mag_a_s   = neg_x(i_operand_a, sign_a_s);
    mag_b_s   = neg_x(i_operand_b, sign_b_s);
    b_zero_s  = (i_operand_b == X_ZERO);
    div_ovf_s = ((i_md_op == OP_DIV) || (i_md_op == OP_REM)) &&
                (i_operand_a == X_MIN) && (i_operand_b == X_ONES);
    special_s = i_md_op[2] && (b_zero_s || div_ovf_s);
    // op[1] separates the remainder flavours from the quotient flavours.
    if (b_zero_s) begin
      special_res_s = i_md_op[1] ? i_operand_a : X_ONES;
    end else if (div_ovf_s) begin
      special_res_s = i_md_op[1] ? X_ZERO : X_MIN;
    end else begin
      special_res_s = X_ZERO;
    end
  end

  // One iteration step for each algorithm and the final sign fix / half select.
  always_comb begin
    // Shift-add: add the multiplicand to the upper half when the current
    // multiplier bit (acc bit 0) is set, then shift the whole product right.
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
    // Restoring divide: shift the next dividend bit into the partial remainder
    // and keep the difference only when it did not go negative.
    div_rem_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff_s = div_rem_s - {1'b0, mcand_q};
    if (div_diff_s[XLEN]) begin
      div_next_s = {div_rem_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod_fix_s = neg_2x(acc_q, neg_q);
    quo_fix_s  = neg_x(acc_q[XLEN-1:0], neg_q);
    rem_fix_s  = neg_x(acc_q[2*XLEN-1:XLEN], neg_q);
    if (op_q[2]) begin
      fix_res_s = op_q[1] ? rem_fix_s : quo_fix_s;
    end else if (op_q == OP_MUL) begin
      fix_res_s = prod_fix_s[XLEN-1:0];
    end else begin
      fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state and datapath-load logic; flush overrides every state.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = i_md_op;
          tag_d = i_tag;
          // Remainder takes the dividend's sign; everything else sa^sb.
          neg_d = (i_md_op[2] && i_md_op[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
          if (i_md_op[2]) begin
            mcand_d = mag_b_s;
            acc_d   = {X_ZERO, mag_a_s};
          end else begin
            mcand_d = mag_a_s;
            acc_d   = {X_ZERO, mag_b_s};
          end
          if (special_s) begin
            result_d = special_res_s;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d = op_q[2] ? div_next_s : mul_next_s;
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = S_FIX;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_FIX: begin
        result_d = fix_res_s;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'b000;
      tag_q    <= {TAG_W{1'b0}};
      neg_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= X_ZERO;
      acc_q    <= {(2*XLEN){1'b0}};
      result_q <= X_ZERO;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_tag    = tag_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_md_op;
  logic [XLEN-1:0]  i_operand_a;
  logic [XLEN-1:0]  i_operand_b;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_result;
  logic [TAG_W-1:0] o_tag;

  alu_muldiv_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_md_op(i_md_op), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_tag(i_tag), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_tag(o_tag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        spec;
  } vec_t;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } sb_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];
  sb_t  sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a request, push its expected result, and step over the accept edge.
  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit push);
    sb_t e;
    i_valid = 1'b1; i_md_op = op; i_operand_a = a; i_operand_b = b; i_tag = tag;
    if (push) begin
      e.res = exp; e.tag = tag;
      sb_q.push_back(e);
    end
    tick();
    i_valid     = 1'b0;
    i_md_op     = 3'($urandom);
    i_operand_a = $urandom;
    i_operand_b = $urandom;
    i_tag       = TAG_W'($urandom);
  endtask

  // Edges after the accept edge until o_valid is seen (0 = visible right away).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input string name);
    sb_t e;
    if (o_valid !== 1'b1) begin
      check({name, "_timeout"}, {31'd0, o_valid}, 32'd1);
    end else if (sb_q.size() == 0) begin
      check({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({name, "_result"}, o_result, e.res);
      check({name, "_tag"}, 32'(o_tag), 32'(e.tag));
    end
  endtask

  task automatic run_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input logic [TAG_W-1:0] tag, input logic spec);
    int lat;
    drive_req(op, a, b, tag, exp, 1'b1);
    wait_valid(lat);
    // Normal ops take XLEN+1 edges; special cases are in DONE right after accept.
    check({name, "_latency"}, 32'(lat), spec ? 32'd0 : 32'(XLEN + 1));
    collect(name);
    tick();
  endtask

  initial begin
    int  lat;
    bit  seen;

    i_reset = 1'b1; i_valid = 1'b0; i_md_op = 3'd0; i_operand_a = 32'd0;
    i_operand_b = 32'd0; i_tag = 5'd0; i_flush = 1'b0; i_ready = 1'b1;

    vecs[0]  = '{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{REMU,   32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[12] = '{MUL,    32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0};
    vecs[13] = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0};
    vecs[14] = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[15] = '{DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[16] = '{MULHSU, 32'd2,        32'h80000000, 32'd1,        1'b0};
    vecs[17] = '{DIV,    32'h80000000, 32'd2,        32'hC0000000, 1'b0};
    vecs[18] = '{MUL,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[19] = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[20] = '{REM,    32'd5,        32'd0,        32'd5,        1'b1};
    vecs[21] = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};

    #2;
    check("reset_ready",  {31'd0, o_ready}, 32'd1);
    check("reset_valid",  {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result, 32'd0);
    check("reset_tag",    32'(o_tag), 32'd0);
    tick(); tick();
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
              TAG_W'(i + 3), vecs[i].spec);
    end

    // DONE held with i_ready low while new requests are offered.
    i_ready = 1'b0;
    drive_req(MULHU, 32'h80000000, 32'd4, 5'd9, 32'd2, 1'b1);
    wait_valid(lat);
    collect("hold_first");
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_md_op = 3'($urandom); i_operand_a = $urandom;
      i_operand_b = $urandom; i_tag = TAG_W'($urandom);
      tick();
      check("hold_result", o_result, 32'd2);
      check("hold_tag",    32'(o_tag), 32'd9);
      check("hold_ready",  {31'd0, o_ready}, 32'd0);
      check("hold_valid",  {31'd0, o_valid}, 32'd1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check("release_ready", {31'd0, o_ready}, 32'd1);
    check("release_valid", {31'd0, o_valid}, 32'd0);

    // Flush landing on BUSY iteration 10.
    drive_req(MUL, 32'd3, 32'd5, 5'd4, 32'd15, 1'b0);
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_ready", {31'd0, o_ready}, 32'd1);
    check("flush_valid", {31'd0, o_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_valid", {31'd0, seen}, 32'd0);

    // Flush together with a request in IDLE: nothing is accepted.
    i_valid = 1'b1; i_flush = 1'b1; i_md_op = DIV; i_operand_a = 32'd9; i_operand_b = 32'd0;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_blocks_accept", {31'd0, o_ready}, 32'd1);
    tick();
    check("flush_blocks_valid", {31'd0, o_valid}, 32'd0);

    // Asynchronous reset in the middle of BUSY, then a clean MULHU.
    drive_req(DIV, 32'd100, 32'd7, 5'd17, 32'd14, 1'b0);
    repeat (5) tick();
    i_reset = 1'b1;
    #1;
    check("midreset_ready",  {31'd0, o_ready}, 32'd1);
    check("midreset_valid",  {31'd0, o_valid}, 32'd0);
    check("midreset_result", o_result, 32'd0);
    check("midreset_tag",    32'(o_tag), 32'd0);
    tick();
    i_reset = 1'b0;
    tick();
    run_vec("post_reset_mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd21, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
